// File: rtl/estados_pkg.sv
// estados_pkg
// Shared state encodings of the 4-state sequence FSM. The sequence FSM and
// decodificador_de_estado both import this package so the two sides can never
// disagree on how S0..S3 are encoded.
//   ESTADO_W  : width of the state code (2 bits)
//   estado_t  : S0=00, S1=01, S2=10, S3=11
//   ERR_CNT_W : width of the optional illegal-transition counter

package estados_pkg;

  localparam int ESTADO_W  = 2;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [ESTADO_W-1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } estado_t;

endpackage

// File: rtl/transicion_a_bit.sv
// transicion_a_bit
// Combinational decode of one observed transition prev -> estado_in.
// A legal transition carries one data bit. A transition that the sequence
// FSM can never make is flagged as not legal.
// Ports:
//   prev      in  : previously observed state
//   estado_in in  : currently observed state
//   bit_val   out : decoded data bit (meaningful only when legal=1)
//   legal     out : 1 when prev -> estado_in is a legal transition

module transicion_a_bit
  import estados_pkg::*;
(
  input  logic [ESTADO_W-1:0] prev,
  input  logic [ESTADO_W-1:0] estado_in,
  output logic                bit_val,
  output logic                legal
);

  always_comb begin
    bit_val = 1'b0;
    legal   = 1'b0;
    case ({prev, estado_in})
      {S0, S0}: begin bit_val = 1'b1; legal = 1'b1; end
      {S0, S1}: begin bit_val = 1'b0; legal = 1'b1; end
      {S1, S2}: begin bit_val = 1'b1; legal = 1'b1; end
      {S1, S3}: begin bit_val = 1'b0; legal = 1'b1; end
      {S2, S2}: begin bit_val = 1'b1; legal = 1'b1; end
      {S2, S3}: begin bit_val = 1'b0; legal = 1'b1; end
      {S3, S3}: begin bit_val = 1'b1; legal = 1'b1; end
      {S3, S0}: begin bit_val = 1'b0; legal = 1'b1; end
      default:  begin bit_val = 1'b0; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/decodificador_de_estado.sv
// decodificador_de_estado
// Turns the observed state sequence of the 4-state FSM into data words.
// Each en_in cycle decodes prev -> estado_in into one bit, shifted in
// MSB-first. After N_BITS bits the word is copied to a one-deep output
// buffer with a valid/ready handshake. An illegal transition pulses
// error_out, drops the partial word and resynchronises on estado_in.
// Optional feature (macro CONTADOR_ERRORES_EN): adds err_cnt_out, a
// saturating count of illegal transitions.
// Ports:
//   clk          in  : clock, rising edge
//   reset        in  : asynchronous, active-high
//   estado_in    in  : observed FSM state
//   en_in        in  : estado_in valid this cycle
//   ready_in     in  : consumer accepts dato_out this cycle
//   dato_out     out : decoded word, first bit in the MSB
//   valid_out    out : dato_out holds an unaccepted word
//   error_out    out : one-cycle pulse on an illegal transition
//   overflow_out out : sticky, a completed word was dropped
//   err_cnt_out  out : (CONTADOR_ERRORES_EN only) illegal transition count

module decodificador_de_estado
  import estados_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ESTADO_W-1:0] estado_in,
  input  logic                en_in,
  input  logic                ready_in,
  output logic [N_BITS-1:0]   dato_out,
  output logic                valid_out,
  output logic                error_out,
`ifdef CONTADOR_ERRORES_EN
  output logic [ERR_CNT_W-1:0] err_cnt_out,
`endif
  output logic                overflow_out
);

  localparam int              CW   = $clog2(N_BITS);
  localparam logic [CW-1:0]   LAST = CW'(N_BITS - 1);

  logic [ESTADO_W-1:0] prev;
  logic [N_BITS-1:0]   shift_reg;
  logic [CW-1:0]       cnt;

  logic                bit_val;
  logic                legal;
  logic [N_BITS-1:0]   word_next;
  logic                complete;

  transicion_a_bit u_transicion (
    .prev      (prev),
    .estado_in (estado_in),
    .bit_val   (bit_val),
    .legal     (legal)
  );

  assign word_next = {shift_reg[N_BITS-2:0], bit_val};
  assign complete  = en_in & legal & (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= S0;
      shift_reg    <= '0;
      cnt          <= '0;
      dato_out     <= '0;
      valid_out    <= 1'b0;
      error_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      error_out <= en_in & ~legal;

      if (en_in) begin
        // prev follows estado_in on illegal transitions too, which is
        // what resynchronises the decoder to the FSM.
        prev <= estado_in;
        if (legal) begin
          shift_reg <= word_next;
          cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end else begin
          cnt <= '0;
        end
      end

      // One-deep output buffer: a completed word replaces the held one only
      // if the held one is gone or leaving on this same edge.
      if (complete) begin
        if (!valid_out || ready_in) begin
          dato_out  <= word_next;
          valid_out <= 1'b1;
        end else begin
          overflow_out <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef CONTADOR_ERRORES_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_out <= '0;
    end else if (en_in && !legal && (err_cnt_out != '1)) begin
      err_cnt_out <= err_cnt_out + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decodificador_de_estado.sv
module tb_decodificador_de_estado;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   estado_in;
  logic         en_in;
  logic         ready_in;
  logic [N-1:0] dato_out;
  logic         valid_out;
  logic         error_out;
  logic         overflow_out;
`ifdef CONTADOR_ERRORES_EN
  logic [7:0]   err_cnt_out;
`endif

  always #5 clk = ~clk;

  decodificador_de_estado #(.N_BITS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .estado_in    (estado_in),
    .en_in        (en_in),
    .ready_in     (ready_in),
    .dato_out     (dato_out),
    .valid_out    (valid_out),
    .error_out    (error_out),
`ifdef CONTADOR_ERRORES_EN
    .err_cnt_out  (err_cnt_out),
`endif
    .overflow_out (overflow_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected words, pushed when the completing sample is driven and popped
  // when the DUT is expected to present them.
  logic [N-1:0] sb[$];

  logic [1:0]   m_prev;
  int           m_cnt;
  logic [N-1:0] m_shift;
  logic [N-1:0] m_held;
  logic         m_valid;
  logic         m_err;
  logic         m_ovf;
  int           m_ecnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {legal, bit} for the transition p -> c.
  function automatic logic [1:0] decode(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b00_00: return 2'b11;
      4'b00_01: return 2'b10;
      4'b01_10: return 2'b11;
      4'b01_11: return 2'b10;
      4'b10_10: return 2'b11;
      4'b10_11: return 2'b10;
      4'b11_11: return 2'b11;
      4'b11_00: return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_prev  = 2'b00;
    m_cnt   = 0;
    m_shift = '0;
    m_held  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ovf   = 1'b0;
    m_ecnt  = 0;
    sb.delete();
  endtask

  task automatic step(input logic [1:0] s, input logic en, input logic rdy);
    logic [1:0]   d;
    logic         done;
    logic         loaded;
    logic [N-1:0] w;
    estado_in = s;
    en_in     = en;
    ready_in  = rdy;
    done      = 1'b0;
    loaded    = 1'b0;
    m_err     = 1'b0;
    if (en) begin
      d = decode(m_prev, s);
      if (!d[1]) begin
        m_err = 1'b1;
        m_cnt = 0;
        if (m_ecnt < 255) m_ecnt++;
      end else begin
        m_shift = {m_shift[N-2:0], d[0]};
        m_cnt++;
        if (m_cnt == N) begin
          done  = 1'b1;
          m_cnt = 0;
        end
      end
      m_prev = s;
    end
    if (done) begin
      if (!m_valid || rdy) begin
        sb.push_back(m_shift);
        m_valid = 1'b1;
        loaded  = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid_out", valid_out, m_valid);
    check("error_out", error_out, m_err);
    check("overflow_out", overflow_out, m_ovf);
`ifdef CONTADOR_ERRORES_EN
    check("err_cnt_out", err_cnt_out, m_ecnt);
`endif
    if (loaded) begin
      w = sb.pop_front();
      m_held = w;
      check("dato_out_new", dato_out, w);
    end else if (m_valid) begin
      check("dato_out_hold", dato_out, m_held);
    end
  endtask

  // Asserted away from the clock edge so the asynchronous clear is visible
  // before any edge occurs.
  task automatic do_reset();
    en_in    = 1'b0;
    ready_in = 1'b0;
    reset    = 1'b1;
    #1;
    check("rst_valid_async", valid_out, 1'b0);
    check("rst_dato_async", dato_out, '0);
    check("rst_error_async", error_out, 1'b0);
    check("rst_overflow_async", overflow_out, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef CONTADOR_ERRORES_EN
    check("rst_err_cnt", err_cnt_out, 8'd0);
`endif
  endtask

  // Eight samples, states[15:14] driven first.
  task automatic seq8(input logic [15:0] states, input logic rdy);
    logic [15:0] st;
    st = states;
    for (int i = 0; i < 8; i++) begin
      step(st[15:14], 1'b1, rdy);
      st = st << 2;
    end
  endtask

  // S1,S2,S2,S3,S0,S0,S1,S3 from prev=S0 -> 0x64
  localparam logic [15:0] SEQ_64 = 16'b01_10_10_11_00_00_01_11;
  // S3 x8 from prev=S3 -> 0xFF
  localparam logic [15:0] SEQ_S3 = 16'b11_11_11_11_11_11_11_11;

  initial begin
    reset     = 1'b1;
    estado_in = 2'b00;
    en_in     = 1'b0;
    ready_in  = 1'b0;
    model_reset();
    #2;
    do_reset();
    step(2'b00, 1'b0, 1'b0);

    // Reference sequence, held with ready low.
    seq8(SEQ_64, 1'b0);
    check("seq_64_word", dato_out, 8'h64);
    check("seq_64_valid", valid_out, 1'b1);
    step(2'b11, 1'b0, 1'b1);
    check("seq_64_accepted", valid_out, 1'b0);

    // All S0 with en_in gaps that carry garbage states.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b00, 1'b1, 1'b0);
      step(2'b10, 1'b0, 1'b0);
    end
    check("all_s0_word", dato_out, 8'hFF);
    step(2'b00, 1'b0, 1'b1);

    // Three bits, illegal S0->S2, then a fresh word from S2.
    do_reset();
    step(2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
    step(2'b10, 1'b1, 1'b1);
    check("illegal_pulse", error_out, 1'b1);
    step(2'b10, 1'b0, 1'b1);
    check("illegal_pulse_end", error_out, 1'b0);
    seq8(16'b10_11_11_00_01_10_10_11, 1'b1);
    check("resync_word", dato_out, 8'hA6);
`ifdef CONTADOR_ERRORES_EN
    check("err_cnt_one", err_cnt_out, 8'd1);
`endif

    // Overflow: second word dropped while the first is held.
    do_reset();
    seq8(SEQ_64, 1'b0);
    seq8(SEQ_S3, 1'b0);
    check("ovf_held_word", dato_out, 8'h64);
    check("ovf_flag", overflow_out, 1'b1);
    step(2'b11, 1'b0, 1'b1);
    check("ovf_drain_valid", valid_out, 1'b0);
    check("ovf_sticky", overflow_out, 1'b1);

    // Accept on the very edge the next word completes.
    do_reset();
    seq8(SEQ_64, 1'b0);
    for (int i = 0; i < 7; i++) step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b1);
    check("same_edge_word", dato_out, 8'hFF);
    check("same_edge_valid", valid_out, 1'b1);
    check("same_edge_no_ovf", overflow_out, 1'b0);

    // Reset mid-word with a word held; restart decodes against S0.
    do_reset();
    seq8(SEQ_64, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b11, 1'b1, 1'b0);
    do_reset();
    seq8(16'b00_01_11_11_00_00_00_01, 1'b0);
    check("post_reset_word", dato_out, 8'h96);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    // Long run of illegal transitions to drive the error counter to saturation.
    do_reset();
    for (int i = 0; i < 130; i++) begin
      step(2'b10, 1'b1, 1'b1);
      step(2'b00, 1'b1, 1'b1);
    end
`ifdef CONTADOR_ERRORES_EN
    check("err_cnt_saturated", err_cnt_out, 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decodificador_de_estado.md
DECODIFICADOR_DE_ESTADO -- requirements
Module: decodificador_de_estado

Interface
REQ-001 The block SHALL have one parameter, N_BITS, default 8, meaning the number of decoded bits per output word (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port estado_in, input, 2 bits: observed state of the 4-state sequence FSM.
REQ-005 The block SHALL have port en_in, input, 1 bit: estado_in is valid this cycle and is to be decoded.
REQ-006 The block SHALL have port ready_in, input, 1 bit: the consumer accepts dato_out this cycle.
REQ-007 The block SHALL have port dato_out, output, N_BITS: the decoded word, first-decoded bit in the MSB.
REQ-008 The block SHALL have port valid_out, output, 1 bit: dato_out holds an unaccepted word.
REQ-009 The block SHALL have port error_out, output, 1 bit: one-cycle pulse on an illegal transition.
REQ-010 The block SHALL have port overflow_out, output, 1 bit: sticky flag set when a word is lost.

Function
REQ-011 The block SHALL use state encoding S0=00, S1=01, S2=10, S3=11, and SHALL register the previous state (prev) on each en_in=1 cycle.
REQ-012 The block SHALL decode legal transitions prev->estado_in to bit x as follows: S0->S0=1, S0->S1=0, S1->S2=1, S1->S3=0, S2->S2=1, S2->S3=0, S3->S3=1, S3->S0=0.
REQ-013 The block SHALL treat all other pairs (S0->S2, S0->S3, S1->S0, S1->S1, S2->S0, S2->S1, S3->S1, S3->S2) as illegal.
REQ-014 On an illegal transition, the block SHALL pulse error_out for one cycle, shift no bit, clear the bit counter (discarding the partial word), and load prev with estado_in to resynchronise.
REQ-015 On a legal transition, the block SHALL shift x into the shift register LSB side (MSB-first order) and increment the bit counter.
REQ-016 When en_in=0, the block SHALL hold prev, the shift register and the counter unchanged, and error_out SHALL be 0.
REQ-017 On the edge that decodes bit N_BITS, the block SHALL copy the completed word to dato_out, set valid_out, and wrap the counter to 0, so the word is visible one clock after the last sample.
REQ-018 A word SHALL be accepted on a rising edge where valid_out=1 and ready_in=1, which clears valid_out unless REQ-019 applies.
REQ-019 If completion and acceptance occur on the same edge, the block SHALL load the new word and keep valid_out=1.
REQ-020 If a word completes while valid_out=1 and ready_in=0, the block SHALL keep the held word, drop the new one, and set overflow_out until reset.
REQ-021 dato_out SHALL remain stable while valid_out=1.

Reset
REQ-022 Reset SHALL set prev=S0, counter=0, shift register=0, dato_out=0, valid_out=0, error_out=0, and overflow_out=0.
REQ-023 Reset asserted mid-word SHALL discard the partial word and any held word, with no error_out pulse.
REQ-024 After reset release, the first en_in sample SHALL be decoded against prev=S0, matching the FSM reset state.

Configuration
REQ-025 With CONTADOR_ERRORES_EN defined, the block SHALL add output port err_cnt_out (8 bits), counting illegal transitions, saturating at 255, and cleared by reset.
REQ-026 Without CONTADOR_ERRORES_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 The shared package estados_pkg SHALL hold the S0..S3 encodings and the 2-bit state width, and SHALL be used by both this block and the sequence FSM.
REQ-028 Transition legality and bit decoding SHALL be a combinational sub-module transicion_a_bit (inputs prev and estado_in; outputs bit and legal); buffering and handshake SHALL stay in the top module.

Verification
REQ-029 Reset, en_in=1, estado_in S1,S2,S2,S3,S0,S0,S1,S3 -> dato_out=0x64, valid_out=1 one clock after the 8th sample; error_out never set.
REQ-030 Reset, estado_in=S0 for 8 en_in cycles -> dato_out=0xFF; with en_in gaps interleaved -> same result, gaps ignored.
REQ-031 3 legal bits, then S0->S2 -> error_out high one cycle, partial word discarded; next 8 legal bits form a fresh word; err_cnt_out=1 when CONTADOR_ERRORES_EN is defined.
REQ-032 ready_in=0, 16 legal bits (0x64 then 0xFF) -> dato_out stays 0x64, overflow_out=1; then ready_in=1 -> valid_out=0 next cycle.
REQ-033 ready_in=1 on the exact edge the next word completes -> new word loaded, valid_out stays 1, overflow_out stays 0.
REQ-034 Reset asserted after 5 bits with a word held -> valid_out=0 immediately, then 8 bits from S0 give a correct word.
